// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable full/empty thresholds and either
// first-word-fall-through or registered (1-cycle latency) read data.
`timescale 1ns/1ps
module sync_fifo_prog #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 4,
  parameter int FWFT_EN           = 1,
  parameter int PROG_FULL_THRESH  = 12,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  almost_full,
  output logic                  prog_full,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  prog_empty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  valid,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int D  = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(D);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
  localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [D];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Every flag is a pure decode of the registered count, so reset clears them at once.
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= DEPTH_C - 1'b1);
  assign prog_full    = (count_q >= PF_C);
  assign empty        = (count_q == '0);
  assign almost_empty = (count_q <= CW'(1));
  assign prog_empty   = (count_q <= PE_C);
  assign data_count   = count_q;
  assign wr_ack       = wr_ack_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wptr_d  = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = rd_acc ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && full;
      // A simultaneous write into an empty FIFO is serviced, so the read is not an error.
      underflow_q <= rd_en && empty && !wr_en;
    end
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      assign dout  = mem_q[rptr_q];
      assign valid = !empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem_q[rptr_q];
        end
      end
      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives one FWFT and one standard-mode FIFO with identical stimulus and
// scoreboards both against a queue-based model of the stored words.
`timescale 1ns/1ps
module tb_sync_fifo_prog;
  localparam int D  = 16;
  localparam int PF = 12;
  localparam int PE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout_f, dout_s;
  logic [4:0] cnt_f, cnt_s;
  logic full_f, af_f, pf_f, empty_f, ae_f, pe_f, ack_f, ovf_f, val_f, udf_f;
  logic full_s, af_s, pf_s, empty_s, ae_s, pe_s, ack_s, ovf_s, val_s, udf_s;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1),
                   .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)) dut_f (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_f), .full(full_f), .almost_full(af_f), .prog_full(pf_f),
    .empty(empty_f), .almost_empty(ae_f), .prog_empty(pe_f),
    .wr_ack(ack_f), .overflow(ovf_f), .valid(val_f), .underflow(udf_f),
    .data_count(cnt_f));

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(0),
                   .PROG_FULL_THRESH(PF), .PROG_EMPTY_THRESH(PE)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_s), .full(full_s), .almost_full(af_s), .prog_full(pf_s),
    .empty(empty_s), .almost_empty(ae_s), .prog_empty(pe_s),
    .wr_ack(ack_s), .overflow(ovf_s), .valid(val_s), .underflow(udf_s),
    .data_count(cnt_s));

  always #5 clk = ~clk;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_f[$], exp_s[$];
  logic       e_ack = 1'b0, e_ovf = 1'b0, e_udf = 1'b0, e_sval = 1'b0;
  logic [7:0] last_s = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1; applies inputs for one cycle and advances the model at the edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    logic fl, em, wacc, racc;
    wr_en = w; rd_en = r; din = d;
    fl = (mq.size() == D);
    em = (mq.size() == 0);
    wacc = w && !fl;
    racc = r && !em;
    if (racc) begin
      exp_f.push_back(mq[0]);
      exp_s.push_back(mq[0]);
    end
    @(posedge clk);
    if (racc) mq.delete(0);
    if (wacc) mq.push_back(d);
    e_ack  = wacc;
    e_ovf  = w && fl;
    e_udf  = r && em && !w;
    e_sval = racc;
    #1;
  endtask

  task automatic mid_reset();
    wr_en = 1'b0; rd_en = 1'b0;
    #1 rst_n = 1'b0;
    mq.delete(); exp_f.delete(); exp_s.delete();
    e_ack = 1'b0; e_ovf = 1'b0; e_udf = 1'b0; e_sval = 1'b0; last_s = 8'h00;
    #1;
    chk("async_rst_empty_f", 32'(empty_f), 32'd1);
    chk("async_rst_count_f", 32'(cnt_f), 32'd0);
    chk("async_rst_empty_s", 32'(empty_s), 32'd1);
    chk("async_rst_count_s", 32'(cnt_s), 32'd0);
    chk("async_rst_dout_s", 32'(dout_s), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    int n;
    logic [5:0] ef;
    logic [7:0] v;
    n  = mq.size();
    ef = {n == D, n >= D-1, n >= PF, n == 0, n <= 1, n <= PE};
    chk("count_f", 32'(cnt_f), 32'(n));
    chk("count_s", 32'(cnt_s), 32'(n));
    chk("flags_f", 32'({full_f, af_f, pf_f, empty_f, ae_f, pe_f}), 32'(ef));
    chk("flags_s", 32'({full_s, af_s, pf_s, empty_s, ae_s, pe_s}), 32'(ef));
    chk("pulses_f", 32'({ack_f, ovf_f, udf_f}), 32'({e_ack, e_ovf, e_udf}));
    chk("pulses_s", 32'({ack_s, ovf_s, udf_s}), 32'({e_ack, e_ovf, e_udf}));
    chk("valid_f", 32'(val_f), 32'(n != 0));
    chk("valid_s", 32'(val_s), 32'(e_sval));
    if (n != 0) chk("head_f", 32'(dout_f), 32'(mq[0]));
    if (rd_en && val_f) begin
      if (exp_f.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_f: pop presented with no word expected at %0t", $time);
      end else begin
        v = exp_f.pop_front();
        chk("pop_f", 32'(dout_f), 32'(v));
      end
    end
    if (val_s) begin
      if (exp_s.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_s: valid with no word expected at %0t", $time);
      end else begin
        v = exp_s.pop_front();
        last_s = v;
        chk("rd_s", 32'(dout_s), 32'(v));
      end
    end else begin
      chk("hold_s", 32'(dout_s), 32'(last_s));
    end
  end

  initial begin
    int wb;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b0, 8'h11);              // overflow at full
    cycle(1'b1, 1'b1, 8'hEE);              // full, both: read wins
    cycle(1'b1, 1'b0, 8'h11);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);              // underflow at empty
    cycle(1'b1, 1'b1, 8'h77);              // empty, both: write wins
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'h80 + i));

    for (int ph = 0; ph < 6; ph++) begin
      wb = (ph % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 80; i++)
        cycle($urandom_range(0, 99) < wb, $urandom_range(0, 99) >= wb,
              8'($urandom_range(0, 255)));
    end

    while (mq.size() != 0) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    mid_reset();
    cycle(1'b1, 1'b0, 8'hA5);
    cycle(1'b0, 1'b1, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 100; i++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
    while (mq.size() != 0) cycle(1'b0, 1'b1, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    chk("sb_left_f", 32'(exp_f.size()), 32'd0);
    chk("sb_left_s", 32'(exp_s.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
